// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with frame-level debounce, single-key press detection
// and a 4-digit decimal entry buffer supporting clear, backspace and enter.
module keypad_entry #(
  parameter int SCAN_DIV = 500,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [15:0] entry,
  output logic [2:0]  entry_digits,
  output logic [15:0] value,
  output logic        value_valid
);

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB        = 4'(DEBOUNCE);

  typedef enum logic { IDLE, HELD } press_t;

  // A frame result is either NONE (hit=0, code=0) or one key code {row, col}.
  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } result_t;

  typedef enum logic [2:0] { K_DIGIT, K_CLEAR, K_BACK, K_ENTER, K_NOP } key_kind_t;

  logic [3:0]  col_meta, col_sync;
  logic [15:0] dwell;
  logic [1:0]  row_idx;
  logic        tick;

  logic [1:0]  acc_hits;
  logic [3:0]  acc_code;
  result_t     prev_res;
  logic [3:0]  stable;
  press_t      state;
  logic        evt;
  logic [3:0]  evt_code;

  assign tick = (dwell == DWELL_LAST);

  // Scan timing and column synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
      dwell    <= '0;
      row_idx  <= '0;
      row      <= 4'b1110;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      col_meta <= col;
      col_sync <= col_meta;
      if (tick) begin
        dwell   <= '0;
        row_idx <= row_idx + 2'd1;
        row     <= ~(4'b0001 << (row_idx + 2'd1));
      end else begin
        dwell <= dwell + 16'd1;
      end
    end
  end

  logic [3:0] low;
  logic [2:0] n_low, hit_sum;
  logic [1:0] low_col, hits_next;
  logic [3:0] code_next, stable_next;
  result_t    frame_res;
  logic       same, accept;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    low       = ~col_sync;
    n_low     = 3'($countones(low));
    low_col   = 2'd0;
    for (int c = 3; c >= 0; c--)
      if (low[c]) low_col = 2'(c);
    hit_sum   = {1'b0, acc_hits} + n_low;
    hits_next = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_next = (n_low != 3'd0) ? {row_idx, low_col} : acc_code;

    frame_res      = '0;
    frame_res.hit  = (hits_next == 2'd1);
    frame_res.code = frame_res.hit ? code_next : 4'd0;

    same        = (frame_res == prev_res);
    stable_next = !same ? 4'd1 : ((stable >= DEB) ? DEB : stable + 4'd1);
    accept      = (stable_next == DEB) && (!same || stable != DEB);
  end

  // Frame accumulation, debounce and press FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hits <= '0;
      acc_code <= '0;
      prev_res <= '0;
      stable   <= '0;
      state    <= IDLE;
      evt      <= 1'b0;
      evt_code <= '0;
    end else begin
      evt <= 1'b0;
      if (tick) begin
        if (row_idx == 2'd3) begin
          acc_hits <= '0;
          acc_code <= '0;
          prev_res <= frame_res;
          stable   <= stable_next;
          if (accept) begin
            if (!frame_res.hit) begin
              state <= IDLE;
            end else if (state == IDLE) begin
              state    <= HELD;
              evt      <= 1'b1;
              evt_code <= frame_res.code;
            end
          end
        end else begin
          acc_hits <= hits_next;
          acc_code <= code_next;
        end
      end
    end
  end

  key_kind_t  kind;
  logic [3:0] digit;

  always_comb begin
    kind  = K_NOP;
    digit = 4'd0;
    unique case (evt_code)
      4'd0, 4'd1, 4'd2:  begin kind = K_DIGIT; digit = evt_code + 4'd1; end
      4'd4, 4'd5, 4'd6:  begin kind = K_DIGIT; digit = evt_code;        end
      4'd8, 4'd9, 4'd10: begin kind = K_DIGIT; digit = evt_code - 4'd1; end
      4'd13:             begin kind = K_DIGIT; digit = 4'd0;            end
      4'd12:             kind = K_CLEAR;
      4'd14:             kind = K_ENTER;
      4'd15:             kind = K_BACK;
      default:           kind = K_NOP;
    endcase
  end

  // Entry buffer, applied on the edge after the accepting frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry        <= '0;
      entry_digits <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (evt) begin
        case (kind)
          K_DIGIT: if (entry_digits < 3'd4) begin
            entry        <= 16'(entry * 16'd10) + {12'd0, digit};
            entry_digits <= entry_digits + 3'd1;
          end
          K_CLEAR: begin
            entry        <= '0;
            entry_digits <= '0;
          end
          K_BACK: if (entry_digits != 3'd0) begin
            entry        <= entry / 16'd10;
            entry_digits <= entry_digits - 3'd1;
          end
          K_ENTER: if (entry_digits != 3'd0) begin
            value        <= entry;
            value_valid  <= 1'b1;
            entry        <= '0;
            entry_digits <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Frame-level bench for keypad_entry: a keypad model drives col from row, and a
// run-length/press/entry reference model predicts the outputs after each frame.
module tb_keypad_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row, col;
  logic [15:0] entry, value;
  logic [2:0]  entry_digits;
  logic        value_valid;
  logic [15:0] keys;

  int total = 0, bad = 0;
  string keymap = "123A456B789C*0#D";

  // reference model state
  int m_entry, m_digits, m_value, m_valid;
  int prev_res, run;
  bit held;
  int pulses_exp = 0, pulses_seen = 0;

  always #5 clk = ~clk;

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .entry(entry),
    .entry_digits(entry_digits), .value(value), .value_valid(value_valid)
  );

  // ideal keypad: a pressed key shorts its row to its column
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r]) col = col & ~keys[r*4 +: 4];
  end

  always @(negedge clk) if (value_valid === 1'b1) pulses_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int key_of(input byte ch);
    for (int i = 0; i < 16; i++) if (keymap[i] == ch) return i;
    return -1;
  endfunction

  task automatic apply_key(input byte ch);
    if (ch >= 8'h30 && ch <= 8'h39) begin
      if (m_digits < 4) begin
        m_entry  = m_entry * 10 + (ch - 8'h30);
        m_digits = m_digits + 1;
      end
    end else if (ch == 8'h2A) begin
      m_entry = 0; m_digits = 0;
    end else if (ch == 8'h44) begin
      if (m_digits > 0) begin m_entry = m_entry / 10; m_digits = m_digits - 1; end
    end else if (ch == 8'h23) begin
      if (m_digits > 0) begin
        m_value = m_entry; m_valid = 1; pulses_exp++;
        m_entry = 0; m_digits = 0;
      end
    end
  endtask

  task automatic model_frame(input logic [15:0] k);
    int res;
    res = -1;
    if ($countones(k) == 1)
      for (int i = 0; i < 16; i++) if (k[i]) res = i;
    run      = (res == prev_res) ? run + 1 : 1;
    prev_res = res;
    m_valid  = 0;
    if (run == DEBOUNCE) begin
      if (res < 0) held = 0;
      else if (!held) begin held = 1; apply_key(keymap[res]); end
    end
  endtask

  // Entered and left at the falling edge just after a frame starts.
  task automatic frame(input logic [15:0] k, input string tag);
    keys = k;
    @(posedge clk); @(negedge clk);
    check({tag, ".row"},    row,          4'b1110);
    check({tag, ".entry"},  entry,        m_entry);
    check({tag, ".digits"}, entry_digits, m_digits);
    check({tag, ".value"},  value,        m_value);
    check({tag, ".vvalid"}, value_valid,  m_valid);
    repeat (FRAME - 1) @(posedge clk);
    @(negedge clk);
    model_frame(k);
  endtask

  task automatic press(input byte ch, input int hold, input int rel, input string tag);
    for (int i = 0; i < hold; i++) frame(16'(1) << key_of(ch), tag);
    for (int i = 0; i < rel; i++)  frame(16'h0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.row",    row,          4'b1110);
    check("rst.entry",  entry,        0);
    check("rst.digits", entry_digits, 0);
    check("rst.value",  value,        0);
    check("rst.vvalid", value_valid,  0);
    rst = 1'b0;
    m_entry = 0; m_digits = 0; m_value = 0; m_valid = 0;
    prev_res = -1; run = 0; held = 0;
  endtask

  initial begin
    logic [15:0] k;
    rst  = 1'b1;
    keys = 16'h0;
    do_reset();

    press("1", 3, 3, "p1"); press("2", 3, 3, "p2");
    press("3", 3, 3, "p3"); press("4", 3, 3, "p4");
    check("four_digits", entry, 1234);
    press("5", 3, 3, "p5_full");
    check("full_ignored", entry, 1234);
    press("#", 3, 3, "enter");
    check("enter_value", value, 1234);
    press("#", 3, 3, "enter_empty");

    press("9", 3, 3, "p9"); press("8", 3, 3, "p8"); press("7", 3, 3, "p7");
    press("D", 3, 3, "back");
    check("back_entry", entry, 98);
    press("*", 3, 3, "clear");
    press("D", 3, 3, "back_empty");

    press("5", 1, 3, "short");
    for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 16'(1) << key_of("5") : 16'h0, "toggle");
    frame(16'h0, "toggle");
    check("bounce_none", entry_digits, 0);
    press("5", 20, 3, "long");
    check("long_once", entry, 5);

    press("*", 3, 3, "clear2");
    for (int i = 0; i < 3; i++) frame(16'h0003, "same_row");
    for (int i = 0; i < 3; i++) frame(16'h0, "same_row");
    for (int i = 0; i < 3; i++) frame(16'h0011, "same_col");
    for (int i = 0; i < 3; i++) frame(16'h0, "same_col");
    check("ghost_none", entry_digits, 0);
    press("6", 3, 0, "hold6");
    for (int i = 0; i < 3; i++) frame(16'h0044, "add3");
    for (int i = 0; i < 3; i++) frame(16'h0, "add3");
    check("rollover_once", entry, 6);

    press("*", 3, 3, "clear3");
    frame(16'(1) << key_of("7"), "pre_rst");
    keys = 16'(1) << key_of("7");
    repeat (7) @(negedge clk);
    do_reset();
    press("7", 3, 3, "post_rst");
    check("post_rst_entry", entry, 7);

    for (int s = 0; s < 60; s++) begin
      int sel = $urandom_range(0, 9);
      int hold = $urandom_range(1, 3);
      k = 16'h0;
      if (sel < 7)       k = 16'(1) << $urandom_range(0, 15);
      else if (sel == 7) k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      for (int i = 0; i < hold; i++) frame(k, "rand");
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) frame(16'h0, "rand_rel");
    end
    frame(16'h0, "flush");
    check("pulse_count", pulses_seen, pulses_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
